// File: rtl/alu_acc_ctrl_if.sv
// alu_acc_ctrl_if
//   Bundles the two handshake channels of the accumulator sequencer.
//   Command channel : cmd_valid/cmd_ready with {cmd_op[2:0], cmd_data[3:0]}
//   Result channel  : res_valid/res_ready with res_data[3:0]
//   master : the side that issues commands and consumes results
//   slave  : the sequencer itself
interface alu_acc_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl
//   Accumulator-style command sequencer for an external 4-bit combinational
//   ALU. Commands are buffered in a FIFO, popped one at a time, and executed
//   in a two-cycle IDLE -> EXEC rhythm; EMIT parks in WAIT_OUT until the
//   result is accepted.
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   bus (slave)     : command and result handshake channels
//   alu_a/alu_b/alu_sel : registered drive to the ALU
//   alu_result      : combinational ALU output
//   acc             : current accumulator
//   busy            : FIFO non-empty or FSM not IDLE
module alu_acc_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_acc_ctrl_if.slave  bus,
    output logic [3:0]     alu_a,
    output logic [3:0]     alu_b,
    output logic [2:0]     alu_sel,
    input  logic [3:0]     alu_result,
    output logic [3:0]     acc,
    output logic           busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_NOTB  = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_EMIT  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    // FIFO storage: {op, data} per entry
    logic [6:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    state_t     state_q, state_d;
    logic [2:0] op_q,    op_d;
    logic [3:0] opnd_q,  opnd_d;
    logic [3:0] acc_q,   acc_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_sel_q, alu_sel_d;
    logic       res_valid_q, res_valid_d;
    logic [3:0] res_data_q,  res_data_d;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic [2:0] head_op;
    logic [3:0] head_data;

    always_comb begin
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        empty     = (count_q == '0);
        push      = bus.cmd_valid && !full;
        pop       = (state_q == IDLE) && !empty;
        head_op   = fifo_mem_q[rd_ptr_q][6:4];
        head_data = fifo_mem_q[rd_ptr_q][3:0];

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        // Pointers wrap naturally because FIFO_DEPTH is a power of two
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d    = head_op;
                    opnd_d  = head_data;
                    state_d = EXEC;
                    // ALU operands are launched on the pop edge so the
                    // combinational result is ready during EXEC
                    if (head_op <= OP_NOTB) begin
                        alu_a_d   = acc_q;
                        alu_b_d   = head_data;
                        alu_sel_d = head_op;
                    end else begin
                        alu_sel_d = 3'b111;
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                case (op_q)
                    OP_LOAD:  acc_d = opnd_q;
                    OP_CLEAR: acc_d = 4'd0;
                    OP_EMIT: begin
                        res_data_d  = acc_q;
                        res_valid_d = 1'b1;
                        state_d     = WAIT_OUT;
                    end
                    default:  acc_d = alu_result;
                endcase
            end
            WAIT_OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            op_q        <= 3'd0;
            opnd_q      <= 4'd0;
            acc_q       <= 4'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_sel_q   <= 3'b111;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Entry storage needs no reset: the count alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_data};
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sel       = alu_sel_q;
    assign acc           = acc_q;
    assign busy          = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
module tb_alu_acc_ctrl;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           NOTB = 3'd4, LOAD = 3'd5, EMIT = 3'd6, CLEAR = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alu_a, alu_b, alu_result, acc;
    logic [2:0] alu_sel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    alu_acc_ctrl_if bus();

    alu_acc_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .acc        (acc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // The external 4-bit ALU
    function automatic logic [3:0] alu_fn(logic [3:0] a, logic [3:0] b, logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~b;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Commands execute strictly in order, so the accumulator sequence and
    // every EMIT value are known as soon as a command is accepted.
    logic [3:0] m_acc;
    logic [3:0] exp_q[$];
    logic       prev_hold;
    logic [3:0] prev_data;

    task automatic model_apply(logic [2:0] op, logic [3:0] d);
        case (op)
            ADD:   m_acc = 4'((int'(m_acc) + int'(d)) % 16);
            SUB:   m_acc = 4'((int'(m_acc) - int'(d) + 16) % 16);
            AND_:  m_acc = m_acc & d;
            OR_:   m_acc = m_acc | d;
            NOTB:  m_acc = 4'(15 - int'(d));
            LOAD:  m_acc = d;
            EMIT:  exp_q.push_back(m_acc);
            default: m_acc = 4'd0;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_acc     = 4'd0;
            exp_q.delete();
            prev_hold = 1'b0;
            prev_data = 4'd0;
        end else begin
            if (prev_hold) begin
                check("res_valid_hold", bus.res_valid, 1);
                check("res_data_hold", bus.res_data, prev_data);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) check("res_unexpected", bus.res_valid, 0);
                else check("res_data_model", bus.res_data, exp_q.pop_front());
            end
            if (!busy) check("acc_idle_model", acc, m_acc);
            if (bus.cmd_valid && bus.cmd_ready) model_apply(bus.cmd_op, bus.cmd_data);
            prev_hold = bus.res_valid && !bus.res_ready;
            prev_data = bus.res_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end just after a rising edge.
    task automatic push(logic [2:0] op, logic [3:0] d);
        logic ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        check("idle_reached", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic emit_check(string name, logic [3:0] lit);
        logic found = 1'b0;
        push(EMIT, 4'd0);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.res_valid && bus.res_ready) begin
                found = 1'b1;
                check(name, bus.res_data, lit);
            end
        end
        check({name, "_seen"}, found, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 4'd0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 3'b111);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LOAD 5, ADD 3, then EMIT with exact timing
        push(LOAD, 4'd5);
        push(ADD, 4'd3);
        wait_idle();
        check("acc_after_add", acc, 8);
        push(EMIT, 4'd0);                       // accepted at edge E
        @(posedge clk); #1;                     // E+1: popped
        check("emit_e1_valid", bus.res_valid, 0);
        @(posedge clk); #1;                     // E+2
        check("emit_e2_valid", bus.res_valid, 1);
        check("emit_e2_data", bus.res_data, 8);
        @(posedge clk); #1;                     // E+3
        check("emit_e3_valid", bus.res_valid, 0);
        wait_idle();

        // Each ALU op and wrap-around
        push(LOAD, 4'd15);
        push(ADD, 4'd1);
        emit_check("add_wrap", 4'd0);
        push(SUB, 4'd1);
        emit_check("sub_wrap", 4'd15);
        push(AND_, 4'd6);
        emit_check("and6", 4'd6);
        push(OR_, 4'd9);
        emit_check("or9", 4'd15);
        push(NOTB, 4'd5);
        emit_check("notb5", 4'd10);
        push(CLEAR, 4'd9);
        emit_check("clear", 4'd0);
        wait_idle();

        // Result backpressure fills the FIFO
        bus.res_ready = 1'b0;
        push(EMIT, 4'd0);
        push(ADD, 4'd1);
        push(ADD, 4'd1);
        push(ADD, 4'd1);
        check("ready_before_full", bus.cmd_ready, 1);
        push(ADD, 4'd1);
        check("ready_when_full", bus.cmd_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_valid", bus.res_valid, 1);
        check("stall_data", bus.res_data, 0);
        check("stall_busy", busy, 1);
        bus.res_ready = 1'b1;
        wait_idle();
        emit_check("drain_plus4", 4'd4);

        // Continuous stream of eight increments
        push(CLEAR, 4'd0);
        for (int i = 0; i < 8; i++) push(ADD, 4'd1);
        emit_check("stream8", 4'd8);
        wait_idle();

        // Reset while waiting for the result with three commands queued
        bus.res_ready = 1'b0;
        push(LOAD, 4'd9);
        push(EMIT, 4'd0);
        push(ADD, 4'd1);
        push(ADD, 4'd1);
        push(ADD, 4'd1);
        @(posedge clk); #1;
        check("pre_rst_valid", bus.res_valid, 1);
        check("pre_rst_data", bus.res_data, 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.res_valid, 0);
        check("mid_rst_acc", acc, 0);
        check("mid_rst_ready", bus.cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_acc", acc, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", bus.res_valid, 0);
        bus.res_ready = 1'b1;

        // ALU drive during EXEC
        push(LOAD, 4'd7);
        wait_idle();
        push(SUB, 4'd2);
        @(posedge clk); #1;
        check("sub_alu_a", alu_a, 7);
        check("sub_alu_b", alu_b, 2);
        check("sub_alu_sel", alu_sel, 3'b001);
        @(posedge clk); #1;
        check("sub_acc", acc, 5);
        check("sel_kept_idle", alu_sel, 3'b001);
        push(LOAD, 4'd3);
        @(posedge clk); #1;
        check("load_sel", alu_sel, 3'b111);
        check("load_a_hold", alu_a, 7);
        check("load_b_hold", alu_b, 2);
        @(posedge clk); #1;
        check("load_acc", acc, 3);
        push(EMIT, 4'd0);
        @(posedge clk); #1;
        check("emit_sel", alu_sel, 3'b111);
        wait_idle();
        push(ADD, 4'd4);
        @(posedge clk); #1;
        check("add_sel", alu_sel, 3'b000);
        check("add_alu_a", alu_a, 3);
        wait_idle();
        push(CLEAR, 4'd0);
        @(posedge clk); #1;
        check("clear_sel", alu_sel, 3'b111);
        wait_idle();
        check("clear_acc", acc, 0);

        check("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_acc_ctrl.md
# alu_acc_ctrl

Accumulator-style command sequencer for the team's 4-bit combinational ALU (ops add, sub, and, or, not-b; sel 101–111 yield 0000). It accepts a stream of {opcode, 4-bit operand} commands through a valid/ready port and buffers them in a small FIFO. It drives the ALU's a/b/sel inputs with the accumulator and the operand, writes each result back into the accumulator, and emits the accumulator on a valid/ready result port on command.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOTB, 101 LOAD, 110 EMIT, 111 CLEAR
- cmd_data  in  4  operand (ignored by EMIT, CLEAR)
- alu_a  out  4  to ALU a; registered
- alu_b  out  4  to ALU b; registered
- alu_sel  out  3  to ALU sel; registered
- alu_result  in  4  from ALU result (combinational)
- res_valid  out  1  res_data valid
- res_ready  in  1  consumer accepts
- res_data  out  4  emitted accumulator value
- acc  out  4  current accumulator
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Reset values: acc 0, alu_a 0, alu_b 0, alu_sel 111, res_valid 0, res_data 0, FIFO empty, cmd_ready 1, busy 0, state IDLE.
- FIFO: push on cmd_valid && cmd_ready; cmd_ready = !full. Pop only in IDLE when non-empty. Entries leave in strict arrival order. Pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle are both honoured, so the count is unchanged.
- FSM states: IDLE, EXEC, WAIT_OUT.
- IDLE: if the FIFO is non-empty, pop the head and go to EXEC. The pop edge registers the op in an internal op register and sets:
  - ALU ops (000–100): alu_a ← acc, alu_b ← cmd_data, alu_sel ← cmd_op.
  - Other ops: alu_sel ← 111; alu_a/alu_b hold.
- EXEC (one cycle), by op:
  - 000–100: acc ← alu_result, then go to IDLE.
  - LOAD: acc ← operand, then go to IDLE.
  - CLEAR: acc ← 0, then go to IDLE.
  - EMIT: res_data ← acc, res_valid ← 1, then go to WAIT_OUT.
- WAIT_OUT: hold res_valid and res_data stable until res_valid && res_ready at an edge. At that edge, res_valid ← 0 and go to IDLE. The FIFO keeps accepting commands while in this state.
- Arithmetic: all 4-bit, modulo 16, no carry or borrow flag. NOTB ignores acc (acc ← ~operand).
- After returning to IDLE, alu_sel keeps its last value until the next pop.
- busy = (state != IDLE) || FIFO non-empty.

## Timing
- Command pushed at edge E with the FSM in IDLE and the FIFO otherwise empty:
  - pop at edge E+1;
  - EXEC during cycle E+1..E+2;
  - acc updated at edge E+2.
- Throughput: one command per 2 cycles when the result port is not stalled.
- EMIT: res_valid rises at edge E+2 and is held through backpressure. Minimum WAIT_OUT is one cycle (res_ready already high).
- Back-to-back commands: the second is popped on the edge after the first's EXEC edge, so it sees the updated acc.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). In-flight and buffered commands are discarded. res_valid drops without a handshake.
- cmd_ready depends only on the FIFO count (registered), never on cmd_valid.

## Test plan
- Reset, then LOAD 5, ADD 3, EMIT with res_ready=1 → res_data=8. res_valid is high exactly one cycle, at E+2 relative to the EMIT push when the FIFO is otherwise idle. acc=8.
- LOAD 15, ADD 1, EMIT → 0. Then SUB 1, EMIT → 15. Then AND 6, EMIT → 6. Then OR 9, EMIT → 15. Then NOTB 5, EMIT → 10. Then CLEAR, EMIT → 0.
- res_ready=0, then EMIT followed by 4 pushes of ADD 1 (FIFO_DEPTH=4) → cmd_ready falls after the 4th accepted push, and res_data and res_valid stay stable. Raise res_ready → the handshake completes, the FIFO drains, and a final EMIT returns acc+4 mod 16.
- Continuous cmd_valid stream of 8 ADD 1 with res_ready=1 → pushes and pops overlap, no command is lost or reordered, and the final EMIT reports 8.
- Assert rst_n low for one cycle during WAIT_OUT with 3 queued commands → res_valid=0, acc=0, cmd_ready=1, busy=0 immediately. No queued command executes after release.
- Check alu_a/alu_b/alu_sel during each ALU EXEC cycle (e.g. acc=7, SUB 2 → a=7, b=2, sel=001, acc→5), and alu_sel=111 during LOAD/EMIT/CLEAR EXEC.
